// File: rtl/wavegen_pkg.sv
// wavegen_pkg: waveform mode encodings shared by the wavegen_multi block and its users.
`default_nettype none

package wavegen_pkg;

    localparam logic [1:0] MODE_TRI   = 2'd0;
    localparam logic [1:0] MODE_SAW   = 2'd1;
    localparam logic [1:0] MODE_PULSE = 2'd2;
    localparam logic [1:0] MODE_SQR   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/wavegen_multi_if.sv
// wavegen_multi_if: control inputs and sample outputs of the multi-mode waveform generator.
`default_nettype none

interface wavegen_multi_if #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] duty;
    logic             sync;
    logic [WIDTH-1:0] wave_out;
    logic             wrap;

    modport master (
        output en, mode, div, duty, sync,
        input  wave_out, wrap
    );

    modport slave (
        input  en, mode, div, duty, sync,
        output wave_out, wrap
    );
endinterface

`default_nettype wire

// File: rtl/wavegen_prescaler.sv
// wavegen_prescaler: emits one tick every div+1 enabled clocks; clr restarts the count.
`default_nettype none

module wavegen_prescaler #(
    parameter int DIV_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en,
    input  wire logic             clr,
    input  wire logic [DIV_W-1:0] div,
    output logic                  tick
);
    logic [DIV_W-1:0] pre_cnt;

    // Compare with >= so a div lowered below the running count fires at once.
    assign tick = en & ~clr & (pre_cnt >= div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (!en || clr || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: rtl/wavegen_multi.sv
// wavegen_multi: prescaled phase accumulator producing triangle, sawtooth, pulse or square samples.
`default_nettype none

module wavegen_multi
    import wavegen_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
) (
    input  wire logic       base_freq,
    input  wire logic       rst_n,
    wavegen_multi_if.slave  bus
);
    localparam logic [WIDTH:0] PHASE_MAX = '1;

    logic [WIDTH:0]   phase;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] sample;
    logic             tick;
    logic             period_end;

    wavegen_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (base_freq),
        .rst_n (rst_n),
        .en    (bus.en),
        .clr   (bus.sync),
        .div   (bus.div),
        .tick  (tick)
    );

    // tick is already gated by sync, so a restart can never also report a wrap.
    assign period_end = tick && (phase == PHASE_MAX);

    always_comb begin
        sample = '0;
        case (mode_q)
            MODE_TRI:   sample = phase[WIDTH] ? ~phase[WIDTH-1:0] : phase[WIDTH-1:0];
            MODE_SAW:   sample = phase[WIDTH:1];
            MODE_PULSE: sample = (phase[WIDTH:1] < bus.duty) ? '1 : '0;
            MODE_SQR:   sample = phase[WIDTH] ? '0 : '1;
            default:    sample = '0;
        endcase
    end

    always_ff @(posedge base_freq or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= '0;
            mode_q       <= MODE_TRI;
            bus.wave_out <= '0;
            bus.wrap     <= 1'b0;
        end else if (!bus.en) begin
            phase        <= '0;
            mode_q       <= bus.mode;
            bus.wave_out <= '0;
            bus.wrap     <= 1'b0;
        end else begin
            bus.wave_out <= sample;
            bus.wrap     <= period_end;
            if (bus.sync) begin
                phase  <= '0;
                mode_q <= bus.mode;
            end else if (tick) begin
                phase <= phase + 1'b1;
                // Mode changes only land on a period boundary to avoid glitching the waveform.
                if (phase == PHASE_MAX) begin
                    mode_q <= bus.mode;
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_wavegen_multi.sv
// tb_wavegen_multi: directed and randomized checks of wavegen_multi against a cycle-level reference model.
`default_nettype none

module tb_wavegen_multi;
    localparam int WIDTH = 4;
    localparam int DIV_W = 8;
    localparam int NPH   = 1 << (WIDTH + 1);
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    wavegen_multi_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

    wavegen_multi #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .base_freq (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase as an integer position in the period, samples from closed-form shapes.
    int m_pre, m_ph, m_mode, m_wave, m_wrap;

    function automatic int shape(input int ph, input int md, input int duty);
        case (md)
            0:       return (ph < NPH / 2) ? ph : (NPH - 1 - ph);
            1:       return ph / 2;
            2:       return (ph / 2 < duty) ? MAXV : 0;
            default: return (ph < NPH / 2) ? MAXV : 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pre = 0; m_ph = 0; m_mode = 0; m_wave = 0; m_wrap = 0;
        end else if (!bus.en) begin
            m_pre = 0; m_ph = 0; m_mode = int'(bus.mode); m_wave = 0; m_wrap = 0;
        end else begin
            m_wave = shape(m_ph, m_mode, int'(bus.duty));
            if (bus.sync) begin
                m_pre = 0; m_ph = 0; m_mode = int'(bus.mode); m_wrap = 0;
            end else if (m_pre >= int'(bus.div)) begin
                m_wrap = (m_ph == NPH - 1) ? 1 : 0;
                if (m_ph == NPH - 1) m_mode = int'(bus.mode);
                m_ph  = (m_ph + 1) % NPH;
                m_pre = 0;
            end else begin
                m_wrap = 0;
                m_pre  = m_pre + 1;
            end
        end
    end

    task automatic drive(input logic e, input logic [1:0] md, input int d, input int dt, input logic s);
        bus.en = e; bus.mode = md; bus.div = DIV_W'(d); bus.duty = WIDTH'(dt); bus.sync = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.wave_out !== '0 || bus.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: wave_out=%0d wrap=%0b required 0/0", bus.wave_out, bus.wrap);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.wave_out !== '0 || bus.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_en_low: wave_out=%0d wrap=%0b required 0/0", bus.wave_out, bus.wrap);
        end
    endtask

    task automatic test_triangle();
        int wraps = 0;
        drive(1'b1, 2'd0, 0, 0, 1'b0);
        for (int k = 0; k < 2 * NPH; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.wave_out !== WIDTH'(shape(k % NPH, 0, 0))) begin
                n_fail++;
                $display("FAIL triangle[%0d]: wave_out=%0d required %0d", k, bus.wave_out, shape(k % NPH, 0, 0));
            end
            if (bus.wrap === 1'b1) wraps++;
        end
        n_checks++;
        if (wraps != 2) begin
            n_fail++;
            $display("FAIL triangle_wraps: got %0d required 2", wraps);
        end
    endtask

    task automatic test_sawtooth();
        int wraps = 0;
        drive(1'b0, 2'd1, 2, 0, 1'b0);
        @(posedge clk); #1;
        bus.en = 1'b1;
        for (int k = 0; k < 3 * NPH; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.wave_out !== WIDTH'((k / 3) % NPH / 2)) begin
                n_fail++;
                $display("FAIL sawtooth[%0d]: wave_out=%0d required %0d", k, bus.wave_out, (k / 3) % NPH / 2);
            end
            if (bus.wrap === 1'b1) wraps++;
        end
        n_checks++;
        if (wraps != 1) begin
            n_fail++;
            $display("FAIL sawtooth_wraps: got %0d required 1", wraps);
        end
    endtask

    task automatic test_pulse();
        int highs = 0;
        drive(1'b0, 2'd2, 0, 4, 1'b0);
        @(posedge clk); #1;
        bus.en = 1'b1;
        for (int k = 0; k < NPH; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.wave_out !== ((k < 8) ? WIDTH'(MAXV) : WIDTH'(0))) begin
                n_fail++;
                $display("FAIL pulse[%0d]: wave_out=%0d required %0d", k, bus.wave_out, (k < 8) ? MAXV : 0);
            end
            if (bus.wave_out === WIDTH'(MAXV)) highs++;
        end
        n_checks++;
        if (highs != 8) begin
            n_fail++;
            $display("FAIL pulse_high_count: got %0d required 8", highs);
        end
    endtask

    task automatic test_mode_switch();
        int guard = 0;
        drive(1'b0, 2'd0, 0, 0, 1'b0);
        @(posedge clk); #1;
        bus.en = 1'b1;
        while (m_ph != 10 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        bus.mode = 2'd3;
        for (int k = 0; k < 2 * NPH; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.wave_out !== WIDTH'(m_wave) || bus.wrap !== 1'(m_wrap)) begin
                n_fail++;
                $display("FAIL mode_switch[%0d]: wave_out=%0d wrap=%0b required %0d/%0d",
                         k, bus.wave_out, bus.wrap, m_wave, m_wrap);
            end
        end
    endtask

    task automatic test_sync_and_enable();
        int guard = 0;
        drive(1'b0, 2'd0, 0, 0, 1'b0);
        @(posedge clk); #1;
        bus.en = 1'b1;
        while (m_ph != 20 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        bus.sync = 1'b1;
        @(posedge clk); #1;
        bus.sync = 1'b0;
        n_checks++;
        if (bus.wrap !== 1'b0 || bus.wave_out !== WIDTH'(shape(20, 0, 0))) begin
            n_fail++;
            $display("FAIL sync_cycle: wave_out=%0d wrap=%0b required %0d/0", bus.wave_out, bus.wrap, shape(20, 0, 0));
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.wave_out !== WIDTH'(k)) begin
                n_fail++;
                $display("FAIL sync_restart[%0d]: wave_out=%0d required %0d", k, bus.wave_out, k);
            end
        end
        bus.en = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.wave_out !== '0 || bus.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL en_low: wave_out=%0d wrap=%0b required 0/0", bus.wave_out, bus.wrap);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'd3, 0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.wave_out !== '0 || bus.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: wave_out=%0d wrap=%0b required 0/0", bus.wave_out, bus.wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.wave_out !== '0) begin
            n_fail++;
            $display("FAIL post_reset_first_sample: wave_out=%0d required 0", bus.wave_out);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2500; k++) begin
            if (k % 40 == 0) bus.div = DIV_W'($urandom_range(0, 4));
            bus.en   = ($urandom_range(0, 99) < 96);
            bus.sync = ($urandom_range(0, 99) < 3);
            bus.duty = WIDTH'($urandom);
            if ($urandom_range(0, 9) == 0) bus.mode = 2'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (bus.wave_out !== WIDTH'(m_wave) || bus.wrap !== 1'(m_wrap)) begin
                n_fail++;
                $display("FAIL random[%0d]: wave_out=%0d wrap=%0b required %0d/%0d",
                         k, bus.wave_out, bus.wrap, m_wave, m_wrap);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_triangle();
        test_sawtooth();
        test_pulse();
        test_mode_switch();
        test_sync_and_enable();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/wavegen_multi.md
WAVEGEN_MULTI -- requirements
Module: wavegen_multi

Interface
REQ-001 Parameter WIDTH, default 4, is the output sample width in bits; legal range 2..12.
REQ-002 Parameter DIV_W, default 8, is the prescaler divisor width in bits; legal range 1..16.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port base_freq  input  1  is the clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  is the asynchronous active-low reset.
REQ-006 Port en  input  1  is the run enable; when low, the generator is held cleared.
REQ-007 Port mode  input  2  selects the waveform: 0 triangle, 1 sawtooth, 2 pulse, 3 square.
REQ-008 Port div  input  DIV_W  is the prescaler divisor; the phase advances once every div+1 clocks.
REQ-009 Port duty  input  WIDTH  is the pulse-mode threshold, sampled each cycle.
REQ-010 Port sync  input  1  is a single-cycle phase restart request.
REQ-011 Port wave_out  output  WIDTH  is the registered sample output.
REQ-012 Port wrap  output  1  is a registered one-cycle pulse marking the end of each period.

Function
REQ-013 The prescaler counter pre_cnt (DIV_W bits) SHALL assert tick when en=1 and pre_cnt >= div, then clear to 0; otherwise it increments.
REQ-014 The phase counter phase (WIDTH+1 bits) SHALL increment modulo 2^(WIDTH+1) on tick, giving a period of 2^(WIDTH+1)*(div+1) clocks.
REQ-015 Triangle: sample = phase[WIDTH-1:0] when phase[WIDTH]=0, else bitwise NOT of phase[WIDTH-1:0] (0..max, max..0, peaks repeated).
REQ-016 Sawtooth: sample = phase[WIDTH:1].
REQ-017 Pulse: sample = all-ones when phase[WIDTH:1] < duty, else 0; duty=0 gives constant 0.
REQ-018 Square: sample = all-ones when phase[WIDTH]=0, else 0.
REQ-019 wave_out SHALL be registered from the current phase and active mode every cycle, i.e. one clock of latency after phase.
REQ-020 The active mode (mode_q) SHALL load from mode only on a period boundary (tick with phase = all-ones), on sync, or while en=0; mode changes mid-period take effect at the next boundary.
REQ-021 wrap SHALL be 1 for exactly the clock following a tick with phase = all-ones.
REQ-022 When en=0: pre_cnt, phase cleared to 0; wave_out 0 and wrap 0 from the next clock.
REQ-023 sync=1 with en=1 SHALL clear pre_cnt and phase, load mode_q, suppress tick and wrap that cycle; sync beats a simultaneous tick.
REQ-024 A change of div SHALL take effect immediately; if pre_cnt already exceeds the new div, tick fires on the next clock.

Reset
REQ-025 rst_n low SHALL asynchronously clear pre_cnt, phase, wave_out, wrap to 0 and mode_q to triangle.
REQ-026 After rst_n deasserts, the first phase advance SHALL occur no earlier than the first rising edge with en=1.

Structure
REQ-027 A shared package wavegen_pkg SHALL hold the mode encoding constants (MODE_TRI, MODE_SAW, MODE_PULSE, MODE_SQR).
REQ-028 The prescaler SHALL be a separate sub-module wavegen_prescaler (inputs clock, reset, en, clr, div; output tick).

Verification (WIDTH=4, DIV_W=8)
REQ-029 rst_n pulse, en=1, mode=0, div=0 -> wave_out 0,1..15,15..1,0 repeating every 32 clocks, wrap once per 32 clocks.
REQ-030 mode=1, div=2 -> wave_out steps 0..15, each value held 3 clocks per phase step, period 96 clocks.
REQ-031 mode=2, duty=4, div=0 -> wave_out 15 for 8 clocks then 0 for 24 clocks per period.
REQ-032 Switch mode 0->3 at phase 10 -> triangle continues to wrap, square starts at 15 on next period.
REQ-033 sync at phase 20 coincident with tick -> phase restarts at 0, no wrap; en low mid-period -> wave_out 0 next clock.
REQ-034 rst_n low mid-run with en=1 -> all outputs 0 immediately, without waiting for a clock edge.
